memory_responder: RTL and testbench

- Word-addressed main-memory responder for the bus-based CPU datapath.
- Services read/write requests issued from MAR/MDR, with a fixed programmable wait-state latency.
- Returns read data on the word that feeds the datapath's MDR memory-data input, and pulses a completion strobe.
- Sits between the datapath and the control unit. The control unit holds MDRread/MDRin until Done.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/ram_array.sv | 26 ++
 rtl/memory_responder.sv | 143 ++++++++++++++
 tb/tb_memory_responder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the word-addressed memory responder.
// The state enum carries the fixed two-bit encoding used by the responder FSM.
package mem_pkg;

  localparam int MEM_ADDR_W      = 9;
  localparam int MEM_DATA_W      = 32;
  localparam int MEM_WAIT_CYCLES = 2;
  localparam int MEM_CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // With no wait states an accepted request goes straight to the access cycle.
  function automatic state_t first_busy_state(input int unsigned wait_cycles);
    state_t st;
    if (wait_cycles == 32'd0) begin
      st = ST_ACCESS;
    end else begin
      st = ST_WAIT;
    end
    return st;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Storage only: synchronous single-port RAM with a registered, read-first output.
// Deliberately has no reset so contents survive clr.
module ram_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  // Single port: optional write plus a registered read of the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// Main-memory responder: latches a MAR/MDR request, waits WAIT_CYCLES, performs the
// access, and pulses Done (or Err for a simultaneous Read and Write).
module memory_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              Done,
  output logic              Busy,
  output logic              Err
);

  localparam logic [MEM_CNT_W-1:0] LP_WAIT_LOAD = MEM_CNT_W'(WAIT_CYCLES);
  localparam state_t               LP_FIRST_ST  = first_busy_state(WAIT_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [MEM_CNT_W-1:0]  r_cnt;
  logic [MEM_CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  op_t                   r_op;
  logic [DATA_W-1:0]     r_data_out;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_ram_we;
  logic [ADDR_W-1:0]     w_ram_addr;
  logic [DATA_W-1:0]     w_ram_rdata;

  assign w_accept  = (r_state == ST_IDLE) && (Read ^ Write);
  assign w_illegal = (r_state == ST_IDLE) && Read && Write;

  // In IDLE the RAM is addressed straight from the bus so that, with zero wait
  // states, its registered output already holds mem[addr] during ACCESS.
  assign w_ram_addr = (r_state == ST_IDLE) ? addr : r_addr;
  assign w_ram_we   = (r_state == ST_ACCESS) && (r_op == OP_WRITE);

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = LP_FIRST_ST;
          w_cnt_nxt   = LP_WAIT_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - {{(MEM_CNT_W-1){1'b0}}, 1'b1};
        if (r_cnt <= {{(MEM_CNT_W-1){1'b0}}, 1'b1}) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = {MEM_CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {MEM_CNT_W{1'b0}};
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= {MEM_CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request latches: captured only on acceptance, never re-sampled while busy.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
      r_op    <= OP_READ;
    end else if (w_accept) begin
      r_addr  <= addr;
      r_wdata <= data_in;
      r_op    <= Write ? OP_WRITE : OP_READ;
    end
  end

  // Registered outputs; data_out only moves on the ACCESS->DONE edge of a read.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_data_out <= {DATA_W{1'b0}};
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == ST_ACCESS) && (r_op == OP_READ)) begin
        r_data_out <= w_ram_rdata;
      end
      r_done <= (w_state_nxt == ST_DONE);
      r_busy <= (w_state_nxt != ST_IDLE);
      r_err  <= w_illegal;
    end
  end

  assign data_out = r_data_out;
  assign Done     = r_done;
  assign Busy     = r_busy;
  assign Err      = r_err;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against a word-array model.
module tb_memory_responder;

  logic        clk;
  logic        clr;
  logic [1:0]  rd, wr;
  logic [8:0]  ad   [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic [1:0]  done, busy, err;

  logic [31:0] mm     [2][512];
  logic [31:0] exp_do [2];
  int          n_cmp, n_bad;

  typedef struct {
    int          w;
    bit          iswr;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .clr(clr), .Read(rd[0]), .Write(wr[0]), .addr(ad[0]), .data_in(din[0]),
    .data_out(dout[0]), .Done(done[0]), .Busy(busy[0]), .Err(err[0])
  );

  memory_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .clr(clr), .Read(rd[1]), .Write(wr[1]), .addr(ad[1]), .data_in(din[1]),
    .data_out(dout[1]), .Done(done[1]), .Busy(busy[1]), .Err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wc(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input int w, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d): got %h expected %h", name, w, act, exp);
    end
  endtask

  // Hold a request until Done; optionally disturb addr/data after the sampling edge.
  task automatic op(input int w, input bit iswr, input logic [8:0] a, input logic [31:0] d,
                    input bit mut, output logic [31:0] q);
    int n;
    bit seen;
    @(negedge clk);
    ad[w] = a; din[w] = d; rd[w] = !iswr; wr[w] = iswr;
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (mut && n == 1) begin
        ad[w]  = a + 9'd1;
        din[w] = 32'hFFFF_FFFF;
      end
      chk("err_quiet", w, {31'd0, err[w]}, 32'd0);
      if (done[w]) seen = 1'b1;
      else chk("busy_in_flight", w, {31'd0, busy[w]}, 32'd1);
    end
    chk("done_latency", w, n, wc(w) + 2);
    if (iswr) mm[w][a] = d;
    else exp_do[w] = mm[w][a];
    chk("data_out_at_done", w, dout[w], exp_do[w]);
    q = dout[w];
    @(negedge clk); rd[w] = 1'b0; wr[w] = 1'b0;
    @(posedge clk); #1;
    chk("busy_after", w, {31'd0, busy[w]}, 32'd0);
    chk("done_pulse_end", w, {31'd0, done[w]}, 32'd0);
    chk("data_out_hold", w, dout[w], exp_do[w]);
  endtask

  task automatic illegal(input int w, input logic [8:0] a);
    @(negedge clk);
    ad[w] = a; din[w] = 32'h5555_5555; rd[w] = 1'b1; wr[w] = 1'b1;
    @(posedge clk); #1;
    chk("err_pulse", w, {31'd0, err[w]}, 32'd1);
    chk("err_busy", w, {31'd0, busy[w]}, 32'd0);
    chk("err_done", w, {31'd0, done[w]}, 32'd0);
    chk("err_data_out", w, dout[w], exp_do[w]);
    @(negedge clk); rd[w] = 1'b0; wr[w] = 1'b0;
    @(posedge clk); #1;
    chk("err_one_cycle", w, {31'd0, err[w]}, 32'd0);
    chk("err_no_done", w, {31'd0, done[w]}, 32'd0);
  endtask

  function automatic logic [8:0] raddr();
    logic [3:0] lo;
    lo = 4'($urandom_range(0, 15));
    return ($urandom_range(0, 1) == 0) ? {5'h00, lo} : {5'h1F, lo};
  endfunction

  initial begin
    logic [31:0] q;
    n_cmp = 0; n_bad = 0;
    rd = 2'b00; wr = 2'b00;
    for (int w = 0; w < 2; w++) begin
      ad[w] = 9'd0; din[w] = 32'd0; exp_do[w] = 32'd0;
    end
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      chk("reset_data_out", w, dout[w], 32'd0);
      chk("reset_busy", w, {31'd0, busy[w]}, 32'd0);
      chk("reset_done", w, {31'd0, done[w]}, 32'd0);
      chk("reset_err", w, {31'd0, err[w]}, 32'd0);
    end
    @(negedge clk); clr = 1'b0;

    tbl[0] = '{0, 1'b1, 9'h005, 32'h1234_5678, 32'h0};
    tbl[1] = '{0, 1'b0, 9'h005, 32'h0,         32'h1234_5678};
    tbl[2] = '{0, 1'b1, 9'h1FF, 32'hDEAD_BEEF, 32'h0};
    tbl[3] = '{0, 1'b1, 9'h000, 32'h0000_0001, 32'h0};
    tbl[4] = '{0, 1'b0, 9'h1FF, 32'h0,         32'hDEAD_BEEF};
    tbl[5] = '{0, 1'b0, 9'h000, 32'h0,         32'h0000_0001};
    tbl[6] = '{1, 1'b1, 9'h005, 32'h1234_5678, 32'h0};
    tbl[7] = '{1, 1'b0, 9'h005, 32'h0,         32'h1234_5678};
    for (int i = 0; i < 8; i++) begin
      op(tbl[i].w, tbl[i].iswr, tbl[i].a, tbl[i].d, 1'b0, q);
      if (!tbl[i].iswr) chk("tbl_read", tbl[i].w, q, tbl[i].exp);
    end

    // Inputs changed mid-request must not be re-sampled.
    for (int w = 0; w < 2; w++) begin
      op(w, 1'b1, 9'h011, 32'h1111_0011, 1'b0, q);
      op(w, 1'b1, 9'h010, 32'hAAAA_0000, 1'b1, q);
      op(w, 1'b0, 9'h010, 32'h0, 1'b0, q);
      chk("busy_ignore_010", w, q, 32'hAAAA_0000);
      op(w, 1'b0, 9'h011, 32'h0, 1'b0, q);
      chk("busy_ignore_011", w, q, 32'h1111_0011);
    end

    // Illegal request leaves memory and data_out untouched.
    for (int w = 0; w < 2; w++) begin
      op(w, 1'b1, 9'h020, 32'h0202_0202, 1'b0, q);
      illegal(w, 9'h020);
      op(w, 1'b0, 9'h020, 32'h0, 1'b0, q);
      chk("illegal_mem", w, q, 32'h0202_0202);
    end

    // Asynchronous reset in the middle of a write's wait states.
    op(0, 1'b1, 9'h030, 32'h3030_3030, 1'b0, q);
    op(1, 1'b0, 9'h005, 32'h0, 1'b0, q);
    @(negedge clk);
    ad[0] = 9'h030; din[0] = 32'hCAFE_F00D; wr[0] = 1'b1;
    @(posedge clk); #2;
    clr = 1'b1;
    #1;
    exp_do[0] = 32'd0; exp_do[1] = 32'd0;
    for (int w = 0; w < 2; w++) begin
      chk("midreset_busy", w, {31'd0, busy[w]}, 32'd0);
      chk("midreset_done", w, {31'd0, done[w]}, 32'd0);
      chk("midreset_data_out", w, dout[w], 32'd0);
    end
    @(negedge clk); wr[0] = 1'b0; clr = 1'b0;
    op(0, 1'b0, 9'h030, 32'h0, 1'b0, q);
    chk("midreset_mem", 0, q, 32'h3030_3030);

    // Randomized traffic over a small address set including both ends of memory.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 32; i++) begin
        logic [8:0] a;
        a = (i < 16) ? 9'(i) : (9'h1F0 + 9'(i - 16));
        op(w, 1'b1, a, $urandom, 1'b0, q);
      end
      for (int i = 0; i < 120; i++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) illegal(w, raddr());
        else op(w, (k < 5), raddr(), $urandom, 1'b0, q);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
